// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Purpose: Shared types and constants for the load/store unit. Holds the FSM
//          state type, the RV32I load/store funct3 encodings and the access
//          legality check used when a request is accepted.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // High when the access must be rejected without touching memory: an
  // encoding that does not exist for the direction, or a half/word access
  // that is not naturally aligned.
  function automatic logic lsu_access_err(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (we) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Purpose: Combinational byte-lane logic for the load/store unit.
//          load_data  : selected byte/half/word of 'word', sign- or
//                       zero-extended according to funct3.
//          store_data : 'word' with the addressed byte/half replaced by the
//                       low bits of 'wdata' (whole word for SW).
// Ports  : word, wdata (32) ; addr_lo (2) ; funct3 (3) ;
//          load_data, store_data (32, outputs)
// Rev    : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data = {24'd0, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data = {16'd0, w_half};
      F3_W:    load_data = word;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    store_data = word;
    case (funct3)
      F3_B:    store_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_data = wdata;
      default: store_data = word;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module : lsu_rmw
// Purpose: Multi-cycle RV32I load/store unit in front of a word-only data
//          memory. Sub-word stores are done as read-modify-write; illegal or
//          misaligned accesses are answered with an error and no memory
//          traffic.
// Ports  : clk, reset (sync, active-high)
//          req_valid/req_ready handshake with req_we, req_funct3,
//          req_addr, req_wdata
//          resp_valid (1-cycle pulse), resp_rdata, resp_err
//          mem_we, mem_addr (word aligned), mem_wdata, mem_rdata (comb.)
// Rev    : 1.0  initial release
// ============================================================================
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // The memory is indexed by addr[11:2]; a deeper memory or a narrower bus
  // cannot be addressed by this unit.
  if ((MEM_WORDS < 1) || (MEM_WORDS > 1024) || (ADDR_W < 12)) begin : g_bad_cfg
    $error("lsu_rmw: MEM_WORDS must be 1..1024 and ADDR_W at least 12");
  end

  lsu_state_e        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_req_err;
  logic              w_mem_phase;
  logic [ADDR_W-1:0] w_word_addr;
  logic [31:0]       w_align_word;
  logic [31:0]       w_load_data;
  logic [31:0]       w_store_data;

  assign w_req_err   = lsu_access_err(req_we, req_funct3, req_addr[1:0]);
  assign w_mem_phase = (r_state == S_READ) || (r_state == S_WRITE);
  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // Loads extract straight from the live read data in READ; the merge in
  // WRITE works on the word captured during READ.
  assign w_align_word = (r_state == S_READ) ? mem_rdata : r_word;

  lsu_align u_align (
    .word       (w_align_word),
    .wdata      (r_wdata),
    .addr_lo    (r_addr[1:0]),
    .funct3     (r_funct3),
    .load_data  (w_load_data),
    .store_data (w_store_data)
  );

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP) && !reset;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Write strobe is gated by reset directly so a reset landing on the WRITE
  // cycle can never corrupt memory.
  assign mem_we    = (r_state == S_WRITE) && !reset;
  assign mem_addr  = w_mem_phase ? w_word_addr : r_mem_addr;
  assign mem_wdata = (r_state == S_WRITE) ? w_store_data : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_word     <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= 32'd0;
            r_err    <= w_req_err;
            if (w_req_err) begin
              r_state <= S_RESP;
            end else if (req_we && (req_funct3 == F3_W)) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_word     <= mem_rdata;
          r_mem_addr <= w_word_addr;
          if (r_we) begin
            r_state <= S_WRITE;
          end else begin
            r_rdata <= w_load_data;
            r_state <= S_RESP;
          end
        end
        S_WRITE: begin
          r_mem_addr <= w_word_addr;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : lsu_rmw
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_rmw
// Purpose: Self-checking bench for lsu_rmw. A behavioural data memory sits on
//          the mem_* port; a reference memory image and access model predict
//          every response, which a monitor compares as responses appear.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lsu_rmw;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cyc;
    int          nwe;
    logic [31:0] waddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_resp   = 0;
  int   cyc      = 0;
  int   we_cnt   = 0;
  logic [31:0] we_addr = 32'd0;

  lsu_rmw #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, word write, synchronous clear.
  assign mem_rdata = dmem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
    end else if (mem_we) begin
      dmem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, req, $time);
    else n_pass++;
  endtask

  task automatic note_fail(input string nm);
    n_checks++;
    $display("FAIL %s: got no event expected one (t=%0t)", nm, $time);
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
  endtask

  // Reference model: predicts the response and updates the reference image.
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output exp_t e);
    int          sz, sh, idx;
    bit          legal, mis;
    logic [31:0] w, b, h;
    idx = int'(a[11:2]);
    sh  = 8 * int'(a % 4);
    sz  = int'(f3 % 4);
    legal = we ? (f3 <= 2) : ((f3 <= 2) || (f3 == 4) || (f3 == 5));
    mis   = ((sz == 1) && (a % 2 != 0)) || ((sz == 2) && (a % 4 != 0));
    e.err = !legal || mis;
    e.rdata = 32'd0;
    e.nwe   = 0;
    e.waddr = a & ~32'h3;
    e.cyc   = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (we) begin
      e.nwe = 1;
      w = ref_mem[idx];
      if (sz == 2) begin
        w = d;
        e.lat = 2;
      end else if (sz == 0) begin
        w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        e.lat = 3;
      end else begin
        w = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        e.lat = 3;
      end
      ref_mem[idx] = w;
    end else begin
      e.lat = 2;
      w = ref_mem[idx];
      b = (w >> sh) & 32'hFF;
      h = (w >> sh) & 32'hFFFF;
      case (f3)
        3'd0:    e.rdata = (b >= 128)   ? b - 32'd256   : b;
        3'd4:    e.rdata = b;
        3'd1:    e.rdata = (h >= 32768) ? h - 32'd65536 : h;
        3'd5:    e.rdata = h;
        default: e.rdata = w;
      endcase
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    int   t, start;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      note_fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    model_op(we, f3, a, d, e);
    e.cyc = cyc + e.lat;
    start = n_resp;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble the request bus while busy; the unit must use its latches.
    req_valid = 1'b0; req_we = 1'($urandom()); req_funct3 = 3'($urandom());
    req_addr = $urandom(); req_wdata = $urandom();
    t = 0;
    while (n_resp == start && t < 10) begin @(negedge clk); t++; end
    if (n_resp == start) begin
      note_fail("resp_timeout");
      exp_q.delete();
    end
  endtask

  // Start an SB and assert reset during its READ (stage 1) or WRITE (stage 2).
  task automatic reset_during(input int stage);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h40; req_wdata = $urandom();
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (stage == 2) begin @(posedge clk); #1; end
    reset = 1'b1;
    ref_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    chk("no_resp_after_reset", {31'd0, resp_valid}, 32'd0);
  endtask

  // Monitor: compares every response against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("we_during_reset", {31'd0, mem_we}, 32'd0);
        we_cnt = 0;
      end else begin
        if (mem_we) begin
          we_cnt++;
          we_addr = mem_addr;
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("latency_cycle", cyc, e.cyc);
            chk("mem_we_count", we_cnt, e.nwe);
            if (e.nwe != 0) chk("mem_we_addr", we_addr, e.waddr);
            chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
          end
          we_cnt = 0;
          n_resp++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, bad;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    ref_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);

    // SW then LW
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    // SB into lane 1, read back
    issue(1'b1, 3'b000, 32'h11, 32'h55);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    // extension cases
    issue(1'b1, 3'b010, 32'h20, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h23, 32'h0);
    issue(1'b0, 3'b100, 32'h23, 32'h0);
    issue(1'b0, 3'b001, 32'h20, 32'h0);
    issue(1'b0, 3'b101, 32'h22, 32'h0);
    // misaligned and illegal
    issue(1'b1, 3'b001, 32'h13, 32'h1234);
    issue(1'b0, 3'b010, 32'h06, 32'h0);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);

    // reset in the middle of a read-modify-write
    reset_during(1);
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    issue(1'b1, 3'b010, 32'h44, 32'hA5A5A5A5);
    reset_during(2);
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    issue(1'b0, 3'b010, 32'h44, 32'h0);

    // randomized traffic, mostly legal, occasional high address bits
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom());
      if ($urandom_range(0, 4) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          r  = $urandom_range(0, 4);
          f3 = (r < 3) ? 3'(r) : 3'(r + 1);
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom());
      issue(we, f3, a, $urandom());
    end

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
    chk("mem_image_mismatches", bad, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_lsu_rmw
`default_nettype wire

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Multi-cycle load/store unit placed directly upstream of the word-addressed data memory (1024 x 32, word-only write enable, combinational read, synchronous clear on reset).
- Accepts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) from the core via a valid/ready handshake.
- Performs byte-lane extraction and sign/zero extension on loads.
- Implements SB/SH as read-modify-write, because the memory has no byte enables.
- Flags misaligned or unsupported accesses without touching memory.

Parameters:
ADDR_W, 32, byte-address width of core and memory buses
MEM_WORDS, 1024, memory depth in words; word index = addr[11:2], upper bits ignored

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  core presents an access
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/half used for SB/SH
resp_valid  output  1  one-cycle pulse marking completion
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
mem_we  output  1  to data memory we
mem_addr  output  32  to data memory addr; word-aligned (bits[1:0] = 0)
mem_wdata  output  32  to data memory wdata
mem_rdata  input  32  from data memory rdata (combinational)

Behaviour:
Reset
- State goes to IDLE; all request latches cleared.
- resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0.
- mem_we is forced 0 combinationally whenever reset=1, including mid-operation. Any in-flight access is dropped with no response.

Request capture and decode
- On accept, latch we, funct3, addr, wdata.
- Decode is performed on the latched values.
- Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Everything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.

FSM states: IDLE, READ, WRITE, RESP
- IDLE: req_ready=1; on accept the next state is:
  - RESP with err when misaligned or illegal
  - WRITE for SW
  - READ otherwise (any load, SB, SH)
- READ: mem_addr={addr[31:2],2'b00}; capture mem_rdata into word_q. Next state is WRITE for SB/SH, RESP for loads.
- WRITE: mem_we=1, mem_addr=word address.
  - SW: mem_wdata=wdata.
  - SB: word_q with lane addr[1:0] replaced by wdata[7:0].
  - SH: word_q with lanes addr[1]*2 +: 2 replaced by wdata[15:0].
  - Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err are registered and stable during RESP.

Latency, accept edge to resp_valid cycle
- Error: 1 cycle
- SW: 2 cycles
- Loads: 2 cycles
- SB/SH: 3 cycles
- Back-to-back: the next request is accepted no earlier than the cycle after RESP, giving 1 idle/accept cycle between accesses.

Load extension
- LB: sign-extend the selected byte. LBU: zero-extend it.
- LH: sign-extend the selected half. LHU: zero-extend it.
- LW: full word.

Other rules
- mem_we is high only in WRITE, for exactly one cycle per store; never on error.
- Outside READ/WRITE, mem_addr holds its last value and mem_wdata holds 0.
- Address bits above the memory range are passed through; the memory ignores them.
- req_* inputs are ignored outside IDLE.

Decomposition:
- lsu_pkg:
  - lsu_state_e enum (IDLE/READ/WRITE/RESP)
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
- Sub-module lsu_align (combinational), containing:
  - load_extract(word, addr[1:0], funct3) -> 32-bit extended data
  - store_merge(word, wdata, addr[1:0], funct3) -> merged word
- The FSM and registers stay in lsu_rmw.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> one mem_we pulse at word 4; LW returns 0xDEADBEEF after 2 cycles, err=0.
- After the above, SB addr 0x11 wdata 0x55, then LW 0x10 -> memory word 0xDEAD55EF; SB takes 3 cycles with exactly one mem_we.
- Word 0x20 = 0x80FF7F01: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x20 -> 0x00007F01; LHU 0x22 -> 0x000080FF.
- SH addr 0x13, then LW addr 0x06 -> each gives resp_err=1 after 1 cycle, resp_rdata=0, mem_we never asserted.
- funct3=3'b011 load and funct3=3'b100 store -> resp_err=1, no memory write.
- Assert reset during the READ cycle of an SB -> no mem_we, no resp_valid; req_ready=1 the cycle after reset deasserts, and the next LW completes normally.
